// File: rtl/asteroid_field_renderer_pkg.sv
// Shared constants, asteroid record type and frame-update FSM states for the asteroid field renderer.
package asteroid_field_renderer_pkg;

    localparam logic [9:0] H_ACT_START = 10'd144;
    localparam logic [9:0] H_ACT_END   = 10'd784;
    localparam logic [9:0] V_ACT_START = 10'd35;
    localparam logic [9:0] V_ACT_END   = 10'd515;
    localparam logic [9:0] FIELD_W     = 10'd640;
    localparam logic [9:0] FIELD_H     = 10'd480;

    localparam logic [11:0] C_SHIP  = 12'h0F0;
    localparam logic [11:0] C_AST   = 12'hFFF;
    localparam logic [11:0] C_BLACK = 12'h000;

    typedef struct packed {
        logic        [9:0] x;
        logic        [9:0] y;
        logic signed [3:0] dx;
        logic signed [3:0] dy;
    } ast_t;

    typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_DONE} fsm_state_t;

    function automatic ast_t ast_init(input int i);
        ast_t a;
        int   d;
        d    = (i % 3) + 1;
        a.x  = 10'((97 * i + 40) % 640);
        a.y  = 10'((61 * i + 20) % 480);
        a.dx = (i % 2 == 0) ? 4'(d) : 4'(-d);
        a.dy = 4'((i % 2) + 1);
        return a;
    endfunction

    // One motion step folded back into [0, lim); |d| is small so a single correction suffices.
    function automatic logic [9:0] wrap_add(input logic [9:0] p, input logic signed [3:0] d,
                                            input logic [9:0] lim);
        logic signed [10:0] n;
        n = $signed({1'b0, p}) + 11'(d);
        if (n >= $signed({1'b0, lim}))
            n = n - $signed({1'b0, lim});
        else if (n < 11'sd0)
            n = n + $signed({1'b0, lim});
        return n[9:0];
    endfunction

endpackage

// File: rtl/asteroid_field_renderer_if.sv
// Pixel-side bundle: pix_en qualifies the counters (no back-pressure); colour, hit, busy and FSM state return.
interface asteroid_field_renderer_if;
    import asteroid_field_renderer_pkg::*;

    logic       pix_en;
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic [9:0] ship_x;
    logic [9:0] ship_y;
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
    logic       hit;
    logic       busy;
    fsm_state_t state;

    modport master (output pix_en, hcount, vcount, ship_x, ship_y,
                    input  red, green, blue, hit, busy, state);
    modport slave  (input  pix_en, hcount, vcount, ship_x, ship_y,
                    output red, green, blue, hit, busy, state);
endinterface

// File: rtl/asteroid_field_renderer_box_hit.sv
// Combinational square-coverage test; the end coordinate is 11 bits so squares clip instead of wrapping.
module asteroid_field_renderer_box_hit #(
    parameter int SIZE = 16
) (
    input  logic [9:0] px_i,
    input  logic [9:0] py_i,
    input  logic [9:0] ox_i,
    input  logic [9:0] oy_i,
    output logic       cover_o
);
    logic [10:0] x_end;
    logic [10:0] y_end;

    assign x_end   = {1'b0, ox_i} + 11'(SIZE);
    assign y_end   = {1'b0, oy_i} + 11'(SIZE);
    assign cover_o = (px_i >= ox_i) && ({1'b0, px_i} < x_end) &&
                     (py_i >= oy_i) && ({1'b0, py_i} < y_end);
endmodule

// File: rtl/asteroid_field_renderer.sv
// Renders ship and asteroid squares into registered RGB and advances asteroid motion once per frame.
module asteroid_field_renderer
    import asteroid_field_renderer_pkg::*;
#(
    parameter int NUM_AST   = 4,
    parameter int AST_SIZE  = 16,
    parameter int SHIP_SIZE = 8
) (
    input logic                      clk,
    input logic                      rst,
    asteroid_field_renderer_if.slave bus
);
    localparam int IW = (NUM_AST > 1) ? $clog2(NUM_AST) : 1;

    fsm_state_t          state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic                hit_q, hit_d;
    logic                collide_q, collide_d;
    logic [9:0]          ship_x_q, ship_y_q;
    logic [11:0]         rgb_q, rgb_d;
    ast_t                ast_q [NUM_AST];
    ast_t                ast_cur, ast_next;

    logic                active;
    logic [9:0]          px, py;
    logic                ship_cov;
    logic [NUM_AST-1:0]  ast_cov;

    assign active = (bus.hcount >= H_ACT_START) && (bus.hcount < H_ACT_END) &&
                    (bus.vcount >= V_ACT_START) && (bus.vcount < V_ACT_END);
    assign px = bus.hcount - H_ACT_START;
    assign py = bus.vcount - V_ACT_START;

    asteroid_field_renderer_box_hit #(.SIZE(SHIP_SIZE)) u_ship_box (
        .px_i(px), .py_i(py), .ox_i(ship_x_q), .oy_i(ship_y_q), .cover_o(ship_cov));

    for (genvar g = 0; g < NUM_AST; g++) begin : g_ast
        asteroid_field_renderer_box_hit #(.SIZE(AST_SIZE)) u_ast_box (
            .px_i(px), .py_i(py), .ox_i(ast_q[g].x), .oy_i(ast_q[g].y), .cover_o(ast_cov[g]));
    end

    always_comb begin
        rgb_d = C_BLACK;
        if (active) begin
            if (ship_cov)      rgb_d = C_SHIP;
            else if (|ast_cov) rgb_d = C_AST;
        end
    end

    // A collision sampled in the DONE cycle survives the end-of-frame clear.
    always_comb begin
        collide_d = collide_q && (state_q != S_DONE);
        if (bus.pix_en && active && ship_cov && (|ast_cov))
            collide_d = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hit_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.pix_en && (bus.hcount == 10'd0) && (bus.vcount == V_ACT_END)) begin
                    state_d = S_UPDATE;
                    idx_d   = '0;
                end
            end
            S_UPDATE: begin
                if (idx_q == IW'(NUM_AST - 1)) begin
                    state_d = S_DONE;
                    hit_d   = collide_d;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ast_cur    = ast_q[idx_q];
        ast_next   = ast_cur;
        ast_next.x = wrap_add(ast_cur.x, ast_cur.dx, FIELD_W);
        ast_next.y = wrap_add(ast_cur.y, ast_cur.dy, FIELD_H);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            hit_q     <= 1'b0;
            collide_q <= 1'b0;
            ship_x_q  <= '0;
            ship_y_q  <= '0;
            rgb_q     <= C_BLACK;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            hit_q     <= hit_d;
            collide_q <= collide_d;
            if (state_q == S_DONE) begin
                ship_x_q <= bus.ship_x;
                ship_y_q <= bus.ship_y;
            end
            if (bus.pix_en)
                rgb_q <= rgb_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_AST; i++)
                ast_q[i] <= ast_init(i);
        end else if (state_q == S_UPDATE) begin
            ast_q[idx_q] <= ast_next;
        end
    end

    assign bus.red   = rgb_q[11:8];
    assign bus.green = rgb_q[7:4];
    assign bus.blue  = rgb_q[3:0];
    assign bus.hit   = hit_q;
    assign bus.busy  = (state_q != S_IDLE);
    assign bus.state = state_q;
endmodule
